// File: rtl/cast_mc_adapter.sv
// cast_mc_adapter: tile<->router local-port adapter with VC injection and per-VC local multicast ejection
module cast_mc_adapter #(
  parameter int DW = 32,
  parameter int VN = 4,
  parameter int NOUT = 2,
  parameter int DEPTH = 4,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [VN-1:0]       local_vc_i,
  input  logic [DW-1:0]       local_data_i,
  input  logic                local_valid_i,
  output logic                local_ready_o,
  output logic [VN-1:0]       local_vc_o,
  output logic [DW-1:0]       local_data_o,
  output logic                local_valid_o,
  input  logic                local_ready_i,
  input  logic [DW-1:0]       tile_data_i,
  input  logic                tile_valid_i,
  output logic                tile_ready_o,
  output logic [NOUT*DW-1:0]  out_data_o,
  output logic [NOUT-1:0]     out_valid_o,
  input  logic [NOUT-1:0]     out_ready_i,
  input  logic [VN-1:0]       cfg_in_vc,
  input  logic [NOUT*VN-1:0]  cfg_out_mask,
  input  logic [NOUT-1:0]     cfg_out_en,
  output logic [CW-1:0]       drop_cnt_o,
  output logic                cfg_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  logic up;
  logic [NOUT-1:0] target, full, push;
  logic acc, drop;
  // full is registered, so output-side pops never reach local_ready_o combinationally
  assign local_ready_o = up && &(~target | ~full);
  assign acc = local_valid_i && local_ready_o;
  assign drop = acc && !(|target);
  assign push = acc ? target : '0;
  for (genvar k = 0; k < NOUT; k++) begin : g_out
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [OW-1:0] cnt;
    logic pop;
    assign target[k] = cfg_out_en[k] && |(local_vc_i & cfg_out_mask[k*VN +: VN]);
    assign full[k] = cnt == OW'(DEPTH);
    assign out_valid_o[k] = cnt != '0;
    assign out_data_o[k*DW +: DW] = out_valid_o[k] ? mem[rp] : '0;
    assign pop = out_valid_o[k] && out_ready_i[k];
    always_ff @(posedge clk)
      if (push[k]) mem[wp] <= local_data_i;
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push[k]) wp <= wp + AW'(1);
        if (pop) rp <= rp + AW'(1);
        cnt <= (push[k] && !pop) ? cnt + OW'(1) : (!push[k] && pop) ? cnt - OW'(1) : cnt;
      end
  end
  logic ov, sv, ov_n, sv_n, trdy, drain, tacc, vc_ok, load;
  logic [DW-1:0] od, sd, od_n, sd_n;
  assign vc_ok = (cfg_in_vc != '0) && ((cfg_in_vc & (cfg_in_vc - VN'(1))) == '0);
  assign drain = ov && local_ready_i;
  assign tacc = tile_valid_i && trdy;
  assign load = drain || !ov;
  // the skid only fills while the output register is stalled and always empties first
  always_comb begin
    ov_n = load ? (sv || tacc) : ov;
    od_n = load ? (sv ? sd : tile_data_i) : od;
    sv_n = load ? (sv && tacc) : (sv || tacc);
    sd_n = tacc ? tile_data_i : sd;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      up <= 1'b0;
      ov <= 1'b0;
      sv <= 1'b0;
      od <= '0;
      sd <= '0;
      trdy <= 1'b0;
      cfg_err_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      up <= 1'b1;
      ov <= ov_n;
      sv <= sv_n;
      od <= od_n;
      sd <= sd_n;
      trdy <= !sv_n && vc_ok;
      cfg_err_o <= !vc_ok;
      if (drop && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CW'(1);
    end
  assign tile_ready_o = trdy;
  assign local_valid_o = ov;
  assign local_data_o = ov ? od : '0;
  assign local_vc_o = ov ? cfg_in_vc : '0;
endmodule

// File: tb/tb_cast_mc_adapter.sv
// tb_cast_mc_adapter: directed self-checking bench for cast_mc_adapter
module tb_cast_mc_adapter;
  localparam int DW = 32, VN = 4, NOUT = 2, DEPTH = 4, CW = 2;
  logic clk = 1'b0, rstn;
  logic [VN-1:0] local_vc_i, local_vc_o, cfg_in_vc;
  logic [DW-1:0] local_data_i, local_data_o, tile_data_i;
  logic local_valid_i, local_ready_o, local_valid_o, local_ready_i;
  logic tile_valid_i, tile_ready_o, cfg_err_o;
  logic [NOUT*DW-1:0] out_data_o;
  logic [NOUT-1:0] out_valid_o, out_ready_i, cfg_out_en;
  logic [NOUT*VN-1:0] cfg_out_mask;
  logic [CW-1:0] drop_cnt_o;
  int checks = 0, failures = 0;
  int sent, n0, n1, ts, nr, low;

  cast_mc_adapter #(.DW(DW), .VN(VN), .NOUT(NOUT), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn),
    .local_vc_i(local_vc_i), .local_data_i(local_data_i), .local_valid_i(local_valid_i),
    .local_ready_o(local_ready_o), .local_vc_o(local_vc_o), .local_data_o(local_data_o),
    .local_valid_o(local_valid_o), .local_ready_i(local_ready_i),
    .tile_data_i(tile_data_i), .tile_valid_i(tile_valid_i), .tile_ready_o(tile_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .cfg_in_vc(cfg_in_vc), .cfg_out_mask(cfg_out_mask), .cfg_out_en(cfg_out_en),
    .drop_cnt_o(drop_cnt_o), .cfg_err_o(cfg_err_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    local_vc_i = '0; local_data_i = '0; local_valid_i = 1'b0; local_ready_i = 1'b1;
    tile_data_i = '0; tile_valid_i = 1'b0;
    cfg_in_vc = 4'b0010; cfg_out_mask = 8'b0010_0001; cfg_out_en = 2'b11; out_ready_i = 2'b11;
    #3;
    chk("rst_lvalid", local_valid_o, 0);
    chk("rst_lvc", local_vc_o, 0);
    chk("rst_ldata", local_data_o, 0);
    chk("rst_ovalid", out_valid_o, 0);
    chk("rst_odata", out_data_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_err", cfg_err_o, 0);
    chk("rst_lrdy", local_ready_o, 0);
    chk("rst_trdy", tile_ready_o, 0);
    tick;
    rstn = 1'b1;
    tick;
    chk("up_lrdy", local_ready_o, 1);
    chk("up_trdy", tile_ready_o, 1);
    // unicast ejection on VC 0001 to output 0
    local_vc_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      local_valid_i = 1'b1;
      local_data_i = 32'hA0 + i;
      #1 chk("uni_rdy", local_ready_o, 1);
      tick;
      chk("uni_valid", out_valid_o, 2'b01);
      chk("uni_data", out_data_o[31:0], 32'hA0 + i);
    end
    local_valid_i = 1'b0;
    tick;
    chk("uni_empty", out_valid_o, 0);
    // multicast to both outputs, output 1 stalled until cycle 8
    cfg_out_mask = 8'b0100_0100;
    local_vc_i = 4'b0100;
    sent = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 40; c++) begin
      local_valid_i = sent < 6;
      local_data_i = 32'hB0 + sent;
      out_ready_i = (c >= 8) ? 2'b11 : 2'b01;
      #3;
      if (c == 4) begin
        chk("mc_stall_rdy", local_ready_o, 0);
        chk("mc_stall_sent", sent, 4);
      end
      if (out_valid_o[0]) begin
        chk("mc_o0", out_data_o[31:0], 32'hB0 + n0);
        n0++;
      end
      if (out_valid_o[1] && out_ready_i[1]) begin
        chk("mc_o1", out_data_o[63:32], 32'hB0 + n1);
        n1++;
      end
      if (local_valid_i && local_ready_o) sent++;
      tick;
    end
    local_valid_i = 1'b0;
    chk("mc_sent", sent, 6);
    chk("mc_n0", n0, 6);
    chk("mc_n1", n1, 6);
    chk("mc_drained", out_valid_o, 0);
    // unmatched VC is consumed and counted, saturating at 3
    cfg_out_mask = 8'b0010_0001;
    local_vc_i = 4'b1000;
    local_data_i = 32'hDD;
    local_valid_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      #1 chk("drop_rdy", local_ready_o, 1);
      tick;
      chk("drop_cnt", drop_cnt_o, i < 3 ? i : 3);
      chk("drop_out", out_valid_o, 0);
    end
    local_valid_i = 1'b0;
    tick;
    // injection stream with one router stall
    ts = 0; nr = 0; low = 0;
    for (int c = 0; c < 30; c++) begin
      tile_valid_i = ts < 8;
      tile_data_i = 32'h10 + ts;
      local_ready_i = c != 4;
      #3;
      if (local_valid_o && local_ready_i) begin
        chk("inj_data", local_data_o, 32'h10 + nr);
        chk("inj_vc", local_vc_o, 4'b0010);
        nr++;
      end
      if (ts < 8 && !tile_ready_o) low++;
      if (tile_valid_i && tile_ready_o) ts++;
      tick;
    end
    tile_valid_i = 1'b0;
    local_ready_i = 1'b1;
    chk("inj_sent", ts, 8);
    chk("inj_recv", nr, 8);
    chk("inj_low", low, 1);
    chk("inj_idle_v", local_valid_o, 0);
    chk("inj_idle_vc", local_vc_o, 0);
    // non-one-hot injection VC blocks the tile
    cfg_in_vc = 4'b0110;
    tick;
    chk("err_flag", cfg_err_o, 1);
    chk("err_trdy", tile_ready_o, 0);
    tile_valid_i = 1'b1;
    tile_data_i = 32'hEE;
    tick;
    tick;
    chk("err_noinj", local_valid_o, 0);
    chk("err_trdy2", tile_ready_o, 0);
    tile_valid_i = 1'b0;
    cfg_in_vc = 4'b0010;
    tick;
    chk("err_clear", cfg_err_o, 0);
    chk("err_trdy3", tile_ready_o, 1);
    // async reset with flits buffered on both paths
    out_ready_i = 2'b00;
    local_ready_i = 1'b0;
    local_vc_i = 4'b0001;
    local_valid_i = 1'b1;
    local_data_i = 32'hC0;
    tile_valid_i = 1'b1;
    tile_data_i = 32'h55;
    tick;
    tile_valid_i = 1'b0;
    local_data_i = 32'hC1;
    tick;
    local_data_i = 32'hC2;
    tick;
    local_valid_i = 1'b0;
    chk("pre_rst_ov", out_valid_o, 2'b01);
    chk("pre_rst_lv", local_valid_o, 1);
    chk("pre_rst_ld", local_data_o, 32'h55);
    chk("pre_rst_drop", drop_cnt_o, 3);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ov", out_valid_o, 0);
    chk("arst_od", out_data_o, 0);
    chk("arst_lv", local_valid_o, 0);
    chk("arst_drop", drop_cnt_o, 0);
    chk("arst_lrdy", local_ready_o, 0);
    tick;
    rstn = 1'b1;
    out_ready_i = 2'b11;
    local_ready_i = 1'b1;
    tick;
    tick;
    local_valid_i = 1'b1;
    local_data_i = 32'hC9;
    #1 chk("post_rdy", local_ready_o, 1);
    tick;
    local_valid_i = 1'b0;
    chk("post_ov", out_valid_o, 2'b01);
    chk("post_od", out_data_o[31:0], 32'hC9);
    tick;
    chk("post_empty", out_valid_o, 0);
    chk("post_lv", local_valid_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
